adc32_seq_ctrl: RTL and testbench

- Multi-cycle 32-bit add/subtract controller that time-shares one SLICE-bit carry-lookahead adder slice.
- The slice uses per-bit generate/propagate with internal lookahead.
- The controller latches the operands, then steps the slice from the LSB group to the MSB group, chaining the carry through a register.
- Final sum and flags are presented with a start/done handshake.
- Sits between the lab top level (switch/button inputs) and the 7-segment display path.

---
 rtl/adc32_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_adc32_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc32_seq_ctrl.sv
// Multi-cycle add/subtract controller: one SLICE-bit carry-lookahead slice is stepped
// LSB group to MSB group, with the carry chained through a register between steps.
module adc32_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             zf
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] r;

    logic [SLICE-1:0] op_a;
    logic [SLICE-1:0] op_b;
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] sum;
    logic [SLICE:0]   c;
    logic             pp;
    logic [WIDTH-1:0] res;
    logic             ov_flag;

    // Each carry is expanded from generate/propagate and the slice carry-in directly,
    // so no carry depends on the previous bit's carry.
    always_comb begin
        op_a = a_r[idx*SLICE +: SLICE];
        op_b = b_r[idx*SLICE +: SLICE];
        g    = op_a & op_b;
        p    = op_a ^ op_b;
        c    = '0;
        pp   = 1'b0;
        c[0] = carry;
        for (int i = 0; i < SLICE; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & carry);
        end
        sum = p ^ c[SLICE-1:0];

        res                       = r;
        res[idx*SLICE +: SLICE]   = sum;
        ov_flag = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[SLICE-1] != a_r[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the accumulator and operand registers are cleared too, so an aborted
            // operation leaves no stale partial result behind.
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
            zf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    r     <= res;
                    carry <= c[SLICE];
                    idx   <= idx + 1'b1;
                    // Results are published together with the done pulse of the DONE cycle.
                    if (idx == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= res;
                        co    <= c[SLICE];
                        ov    <= ov_flag;
                        zf    <= (res == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc32_seq_ctrl.sv
// Scoreboard bench for adc32_seq_ctrl: an acceptance model pushes expected results,
// a negedge monitor pops them on done and checks busy/done timing and output hold.
module tb_adc32_seq_ctrl;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int N      = WIDTH / SLICE;
    localparam int SLICE2 = 4;
    localparam int N2     = WIDTH / SLICE2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             start2 = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;

    logic             busy, done, co, ov, zf;
    logic [WIDTH-1:0] s;
    logic             busy2, done2, co2, ov2, zf2;
    logic [WIDTH-1:0] s2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int next_free = 0;
    int rst_at = -1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        logic             zf;
        int               acc;
    } exp_t;

    exp_t q[$];

    adc32_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .co(co), .ov(ov), .zf(zf)
    );

    adc32_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE2)) dut4 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub), .a(a), .b(b),
        .busy(busy2), .done(done2), .s(s2), .co(co2), .ov(ov2), .zf(zf2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Result computed from plain unsigned/signed arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic op, input int acc);
        exp_t   e;
        longint sx, sy, t;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op) begin
            e.s  = x - y;
            e.co = (x >= y);
            t    = sx - sy;
        end else begin
            {e.co, e.s} = {1'b0, x} + {1'b0, y};
            t = sx + sy;
        end
        e.ov  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        e.zf  = (e.s == '0);
        e.acc = acc;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 16));
            default: return 32'($urandom);
        endcase
    endfunction

    // Acceptance model: a start seen at an edge is taken if the block has been idle long
    // enough; each op occupies N+2 edges before the next one can be accepted.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                next_free = cyc + 1;
                rst_at    = cyc;
            end else if (start && cyc >= next_free) begin
                q.push_back(model(a, b, sub, cyc));
                next_free = cyc + N + 2;
            end
        end
    end

    // Monitor: values seen here are those present just after edge number cyc.
    initial begin
        exp_t             e;
        logic             exp_busy;
        logic [WIDTH-1:0] hs;
        logic             hco, hov, hzf;
        hs = '0; hco = 1'b0; hov = 1'b0; hzf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_at == cyc) begin
                hs = '0; hco = 1'b0; hov = 1'b0; hzf = 1'b0;
            end
            exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].acc + N);
            check("busy", 64'(busy), 64'(exp_busy));
            check("busy_done_excl", 64'(busy & done), 64'(0));
            if (done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done at cycle %0d: got done=1 expected done=0", cyc);
                end else begin
                    e = q.pop_front();
                    check("latency", 64'(cyc - e.acc), 64'(N));
                    hs = e.s; hco = e.co; hov = e.ov; hzf = e.zf;
                end
            end else if (q.size() > 0 && cyc > q[0].acc + N) begin
                total++;
                bad++;
                $display("FAIL done_timeout at cycle %0d: got no done expected one at cycle %0d",
                         cyc, q[0].acc + N);
                void'(q.pop_front());
            end
            check("s", 64'(s), 64'(hs));
            check("co", 64'(co), 64'(hco));
            check("ov", 64'(ov), 64'(hov));
            check("zf", 64'(zf), 64'(hzf));
        end
    end

    task automatic op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic o);
        @(negedge clk);
        a = x; b = y; sub = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 1) begin
            @(negedge clk);
            a = 32'($urandom); b = 32'($urandom); sub = 1'($urandom);
        end
    endtask

    initial begin
        exp_t e;
        int   lat;
        logic busy2_seen;

        repeat (2) @(negedge clk);
        rst = 1'b0;

        op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        op(32'h8000_0000, 32'h0000_0001, 1'b1);
        op(32'h0000_0005, 32'h0000_0007, 1'b1);
        op(32'h0000_0007, 32'h0000_0007, 1'b1);

        // start held high; a changes two edges into the third op's run
        @(negedge clk);
        a = 32'd1; b = 32'd2; sub = 1'b0; start = 1'b1;
        repeat (15) @(negedge clk);
        a = 32'h100;
        repeat (12) @(negedge clk);
        start = 1'b0;
        repeat (N + 3) @(negedge clk);

        // reset three edges after acceptance: the op is dropped, no done follows
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h0000_0003; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 4) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            op(pick(), pick(), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // SLICE=4 instance: eight slice steps
        repeat (3) @(negedge clk);
        a = 32'h0FFF_FFFF; b = 32'h0000_0001; sub = 1'b0; start2 = 1'b1;
        e = model(a, b, sub, 0);
        @(negedge clk);
        start2 = 1'b0;
        busy2_seen = busy2;
        lat = 0;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("slice4_busy", 64'(busy2_seen), 64'(1));
        check("slice4_latency", 64'(lat), 64'(N2));
        check("slice4_s", 64'(s2), 64'(e.s));
        check("slice4_co", 64'(co2), 64'(e.co));
        check("slice4_ov", 64'(ov2), 64'(e.ov));
        check("slice4_zf", 64'(zf2), 64'(e.zf));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
